// File: rtl/pkt_len_norm.sv
// Packet length normaliser: pads short packets up to MIN_LEN with PAD_BYTE and bounds long
// packets at MAX_LEN, either splitting the excess into follow-on packets or dropping it.
// Store-and-forward through a data FIFO plus a segment-length FIFO.
module pkt_len_norm #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       MIN_LEN     = 46,
    parameter int unsigned       MAX_LEN     = 1500,
    parameter bit                SPLIT_MODE  = 1'b1,
    parameter logic [DATA_W-1:0] PAD_BYTE    = '0,
    parameter int unsigned       DFIFO_DEPTH = 2048,
    parameter int unsigned       LFIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              din_sop,
    input  logic              din_eop,
    output logic              din_rdy,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    input  logic              dout_rdy,
    output logic              trunc_pulse,
    output logic              err_pulse
);
    localparam int unsigned LW  = $clog2(MAX_LEN + 1);
    localparam int unsigned DAW = $clog2(DFIFO_DEPTH);
    localparam int unsigned LAW = $clog2(LFIFO_DEPTH);
    localparam int unsigned DCW = DAW + 1;
    localparam int unsigned LCW = LAW + 1;
    localparam logic [LW-1:0]  MinL  = LW'(MIN_LEN);
    localparam logic [LW-1:0]  MaxL  = LW'(MAX_LEN);
    localparam logic [DCW-1:0] DFull = DCW'(DFIFO_DEPTH);
    localparam logic [LCW-1:0] LFull = LCW'(LFIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StData, StPad} state_e;

    logic [DATA_W-1:0] dmem [DFIFO_DEPTH];
    logic [LW-1:0]     lmem [LFIFO_DEPTH];

    logic [DAW-1:0] dwp_q, dwp_d, drp_q, drp_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [LAW-1:0] lwp_q, lwp_d, lrp_q, lrp_d;
    logic [LCW-1:0] lcnt_q, lcnt_d;

    // Write side state
    logic          acc, d_push, l_push, d_pop, l_pop;
    logic [LW-1:0] l_push_len, seg_base, seg_next;
    logic [LW-1:0] seg_cnt_q, seg_cnt_d, pend_len_q, pend_len_d;
    logic          in_pkt_q, in_pkt_d, trunc_done_q, trunc_done_d, pend_q, pend_d;
    logic          din_rdy_q, din_rdy_d, trunc_q, trunc_d, err_q, err_d;

    // Read side state
    state_e            state_q, state_d;
    logic [LW-1:0]     len_r_q, len_r_d, beat_cnt_q, beat_cnt_d, pad_cnt_q, pad_cnt_d, beat_next;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              vld_q, vld_d, sop_q, sop_d, eop_q, eop_d, adv;

    // Segmentation of the input stream and length-entry generation
    always_comb begin
        acc          = din_vld && din_rdy_q;
        in_pkt_d     = in_pkt_q;
        seg_cnt_d    = seg_cnt_q;
        trunc_done_d = trunc_done_q;
        pend_d       = pend_q;
        pend_len_d   = pend_len_q;
        d_push       = 1'b0;
        l_push       = 1'b0;
        l_push_len   = pend_len_q;
        trunc_d      = 1'b0;
        err_d        = 1'b0;
        seg_base     = seg_cnt_q;
        seg_next     = '0;
        // A deferred length entry (second close in one cycle) goes out first; input is stalled
        if (pend_q && (lcnt_q != LFull)) begin
            l_push = 1'b1;
            pend_d = 1'b0;
        end
        if (acc) begin
            if (din_sop) begin
                // sop with a segment still open: close it here, this beat starts a new one
                if (seg_cnt_q != '0) begin
                    err_d      = 1'b1;
                    l_push     = 1'b1;
                    l_push_len = seg_cnt_q;
                end
                seg_base     = '0;
                trunc_done_d = 1'b0;
                d_push       = 1'b1;
            end else if (!in_pkt_q) begin
                err_d        = 1'b1;
                seg_base     = '0;
                trunc_done_d = 1'b0;
                d_push       = 1'b1;
            end else if (!SPLIT_MODE && (seg_cnt_q == '0)) begin
                // Past MAX_LEN in truncate mode: drop beats up to and including eop
                trunc_d      = !trunc_done_q;
                trunc_done_d = 1'b1;
                if (din_eop) begin
                    in_pkt_d = 1'b0;
                end
            end else begin
                d_push = 1'b1;
            end
            if (d_push) begin
                seg_next = seg_base + 1'b1;
                if (din_eop || (seg_next == MaxL)) begin
                    if (l_push) begin
                        pend_d     = 1'b1;
                        pend_len_d = seg_next;
                    end else begin
                        l_push     = 1'b1;
                        l_push_len = seg_next;
                    end
                    seg_cnt_d = '0;
                    in_pkt_d  = !din_eop;
                end else begin
                    seg_cnt_d = seg_next;
                    in_pkt_d  = 1'b1;
                end
            end
        end
    end

    // Read FSM with a registered output stage that only loads when it is empty or being taken
    always_comb begin
        state_d    = state_q;
        len_r_d    = len_r_q;
        beat_cnt_d = beat_cnt_q;
        pad_cnt_d  = pad_cnt_q;
        dout_d     = dout_q;
        vld_d      = vld_q;
        sop_d      = sop_q;
        eop_d      = eop_q;
        d_pop      = 1'b0;
        l_pop      = 1'b0;
        adv        = !vld_q || dout_rdy;
        beat_next  = beat_cnt_q + 1'b1;
        unique case (state_q)
            StIdle: begin
                if (adv) begin
                    vld_d = 1'b0;
                    sop_d = 1'b0;
                    eop_d = 1'b0;
                end
                if (lcnt_q != '0) begin
                    l_pop      = 1'b1;
                    len_r_d    = lmem[lrp_q];
                    beat_cnt_d = '0;
                    state_d    = StData;
                end
            end
            StData: begin
                if (adv) begin
                    dout_d     = dmem[drp_q];
                    vld_d      = 1'b1;
                    sop_d      = (beat_cnt_q == '0);
                    eop_d      = 1'b0;
                    d_pop      = 1'b1;
                    beat_cnt_d = beat_next;
                    // The segment's last stored beat is its len_r-th beat
                    if (beat_next == len_r_q) begin
                        if (len_r_q >= MinL) begin
                            eop_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            pad_cnt_d = MinL - len_r_q;
                            state_d   = StPad;
                        end
                    end
                end
            end
            StPad: begin
                if (adv) begin
                    dout_d    = PAD_BYTE;
                    vld_d     = 1'b1;
                    sop_d     = 1'b0;
                    eop_d     = (pad_cnt_q == LW'(1));
                    pad_cnt_d = pad_cnt_q - 1'b1;
                    if (pad_cnt_q == LW'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO pointer/occupancy bookkeeping and registered input-ready
    always_comb begin
        dwp_d     = d_push ? dwp_q + 1'b1 : dwp_q;
        drp_d     = d_pop ? drp_q + 1'b1 : drp_q;
        dcnt_d    = dcnt_q + DCW'(d_push) - DCW'(d_pop);
        lwp_d     = l_push ? lwp_q + 1'b1 : lwp_q;
        lrp_d     = l_pop ? lrp_q + 1'b1 : lrp_q;
        lcnt_d    = lcnt_q + LCW'(l_push) - LCW'(l_pop);
        din_rdy_d = !pend_d && (dcnt_d != DFull) && (lcnt_d != LFull);
    end

    // FIFO storage (no reset needed; occupancy counters gate every read)
    always_ff @(posedge clk) begin
        if (d_push) begin
            dmem[dwp_q] <= din;
        end
        if (l_push) begin
            lmem[lwp_q] <= l_push_len;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwp_q        <= '0;
            drp_q        <= '0;
            dcnt_q       <= '0;
            lwp_q        <= '0;
            lrp_q        <= '0;
            lcnt_q       <= '0;
            seg_cnt_q    <= '0;
            pend_len_q   <= '0;
            in_pkt_q     <= 1'b0;
            trunc_done_q <= 1'b0;
            pend_q       <= 1'b0;
            din_rdy_q    <= 1'b1;
            trunc_q      <= 1'b0;
            err_q        <= 1'b0;
            state_q      <= StIdle;
            len_r_q      <= '0;
            beat_cnt_q   <= '0;
            pad_cnt_q    <= '0;
            dout_q       <= '0;
            vld_q        <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
        end else begin
            dwp_q        <= dwp_d;
            drp_q        <= drp_d;
            dcnt_q       <= dcnt_d;
            lwp_q        <= lwp_d;
            lrp_q        <= lrp_d;
            lcnt_q       <= lcnt_d;
            seg_cnt_q    <= seg_cnt_d;
            pend_len_q   <= pend_len_d;
            in_pkt_q     <= in_pkt_d;
            trunc_done_q <= trunc_done_d;
            pend_q       <= pend_d;
            din_rdy_q    <= din_rdy_d;
            trunc_q      <= trunc_d;
            err_q        <= err_d;
            state_q      <= state_d;
            len_r_q      <= len_r_d;
            beat_cnt_q   <= beat_cnt_d;
            pad_cnt_q    <= pad_cnt_d;
            dout_q       <= dout_d;
            vld_q        <= vld_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
        end
    end

    assign din_rdy     = din_rdy_q;
    assign dout        = dout_q;
    assign dout_vld    = vld_q;
    assign dout_sop    = sop_q;
    assign dout_eop    = eop_q;
    assign trunc_pulse = trunc_q;
    assign err_pulse   = err_q;

endmodule

// File: tb/tb_pkt_len_norm.sv
// Directed bench for pkt_len_norm: split-mode instance (a) and truncate-mode instance (b).
module tb_pkt_len_norm;
    localparam int MinLen = 46;

    logic clk;
    logic rst;

    logic [7:0] din_a, din_b, dout_a, dout_b;
    logic vld_a, sop_a, eop_a, rdy_a, dvld_a, dsop_a, deop_a, drdy_a, trunc_a, err_a;
    logic vld_b, sop_b, eop_b, rdy_b, dvld_b, dsop_b, deop_b, drdy_b, trunc_b, err_b;

    int n_cmp = 0;
    int n_bad = 0;
    int rdy_mode = 0;  // 0: always ready, 1: ready 1 cycle in 3, 2: never ready
    int ph = 0;

    logic [9:0] outa[$], outb[$], expa[$], expb[$];  // {sop, eop, data}
    int err_cnt_a = 0, err_cnt_b = 0, trunc_cnt_a = 0, trunc_cnt_b = 0;
    int hold_viol = 0;
    bit saw_full = 1'b0;
    bit prev_stall = 1'b0;
    logic [10:0] prev_out;
    int e0;

    pkt_len_norm #(.SPLIT_MODE(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_vld(vld_a), .din_sop(sop_a),
        .din_eop(eop_a), .din_rdy(rdy_a), .dout(dout_a), .dout_vld(dvld_a),
        .dout_sop(dsop_a), .dout_eop(deop_a), .dout_rdy(drdy_a),
        .trunc_pulse(trunc_a), .err_pulse(err_a)
    );

    pkt_len_norm #(.SPLIT_MODE(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_vld(vld_b), .din_sop(sop_b),
        .din_eop(eop_b), .din_rdy(rdy_b), .dout(dout_b), .dout_vld(dvld_b),
        .dout_sop(dsop_b), .dout_eop(deop_b), .dout_rdy(drdy_b),
        .trunc_pulse(trunc_b), .err_pulse(err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream ready pattern
    initial begin
        drdy_a = 1'b1;
        drdy_b = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) begin
                ph = (ph + 1) % 3;
                drdy_a = (ph == 0);
            end else begin
                drdy_a = (rdy_mode == 0);
            end
        end
    end

    // Output capture, pulse counting and stall-stability monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (dvld_a && drdy_a) outa.push_back({dsop_a, deop_a, dout_a});
            if (dvld_b && drdy_b) outb.push_back({dsop_b, deop_b, dout_b});
            if (err_a) err_cnt_a++;
            if (err_b) err_cnt_b++;
            if (trunc_a) trunc_cnt_a++;
            if (trunc_b) trunc_cnt_b++;
            if (!rdy_a) saw_full = 1'b1;
            if (prev_stall && ({dvld_a, dsop_a, deop_a, dout_a} !== prev_out)) hold_viol++;
            prev_stall = dvld_a && !drdy_a;
            prev_out   = {dvld_a, dsop_a, deop_a, dout_a};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_beat(input int which, input logic [7:0] d, input logic s, input logic e);
        int guard = 0;
        if (which == 0) begin
            din_a = d; sop_a = s; eop_a = e; vld_a = 1'b1;
        end else begin
            din_b = d; sop_b = s; eop_b = e; vld_b = 1'b1;
        end
        @(negedge clk);
        while (((which == 0) ? rdy_a : rdy_b) !== 1'b1) begin
            guard++;
            if (guard > 40000) begin
                n_bad++;
                $display("FAIL din_rdy timeout: observed stuck low expected accept");
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $fatal(1, "input stalled");
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (which == 0) vld_a = 1'b0;
        else vld_b = 1'b0;
    endtask

    task automatic send_pkt(input int which, input int n, input int base, input bit s, input bit e);
        for (int i = 0; i < n; i++) begin
            drive_beat(which, 8'(base + i), (i == 0) && s, (i == n - 1) && e);
        end
    endtask

    // Expected output for one segment: data beats then pad beats up to MinLen
    task automatic exp_seg(input int which, input int n, input int base);
        logic [9:0] b;
        for (int i = 0; i < n; i++) begin
            b = {(i == 0), ((i == n - 1) && (n >= MinLen)), 8'(base + i)};
            if (which == 0) expa.push_back(b); else expb.push_back(b);
        end
        for (int p = 0; p < MinLen - n; p++) begin
            b = {1'b0, (p == MinLen - n - 1), 8'h00};
            if (which == 0) expa.push_back(b); else expb.push_back(b);
        end
    endtask

    task automatic check_out(input int which, input string tag);
        logic [9:0] got[$];
        logic [9:0] exp[$];
        logic [9:0] g, e;
        int guard = 0;
        int bad = -1;
        while ((((which == 0) ? outa.size() : outb.size()) <
                ((which == 0) ? expa.size() : expb.size())) && (guard < 30000)) begin
            @(posedge clk);
            guard++;
        end
        repeat (20) @(posedge clk);
        #1;
        if (which == 0) begin got = outa; exp = expa; end
        else begin got = outb; exp = expb; end
        chk({tag, " beat count"}, got.size(), exp.size());
        for (int i = 0; (i < got.size()) && (i < exp.size()); i++) begin
            if (got[i] !== exp[i]) begin
                bad = i;
                break;
            end
        end
        g = '0;
        e = '0;
        if (bad >= 0) begin
            g = got[bad]; e = exp[bad];
        end else if ((exp.size() > 0) && (got.size() > 0)) begin
            g = got[got.size() - 1]; e = exp[exp.size() - 1];
        end
        chk($sformatf("%s beat %0d {sop,eop,data}", tag, bad), g, e);
    endtask

    task automatic clear_q();
        outa.delete(); outb.delete(); expa.delete(); expb.delete();
    endtask

    initial begin
        rst = 1'b1;
        din_a = '0; vld_a = 0; sop_a = 0; eop_a = 0;
        din_b = '0; vld_b = 0; sop_b = 0; eop_b = 0;
        #2;
        chk("reset dout_vld", dvld_a, 0);
        chk("reset dout_sop", dsop_a, 0);
        chk("reset dout_eop", deop_a, 0);
        chk("reset dout", dout_a, 0);
        chk("reset trunc_pulse", trunc_b, 0);
        chk("reset err_pulse", err_a, 0);
        chk("reset din_rdy", rdy_a, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Short packet padded to MinLen
        exp_seg(0, 10, 8'h10);
        send_pkt(0, 10, 8'h10, 1, 1);
        check_out(0, "pad10");
        chk("pad10 first sop", outa[0][9], 1);
        chk("pad10 beat11 pad byte", outa[10][7:0], 8'h00);
        chk("pad10 beat45 no eop", outa[44][8], 0);
        chk("pad10 beat46 eop", outa[45][8], 1);
        clear_q();

        // Exactly MinLen and exactly MaxLen pass unchanged
        exp_seg(0, 46, 3);
        exp_seg(0, 1500, 77);
        send_pkt(0, 46, 3, 1, 1);
        send_pkt(0, 1500, 77, 1, 1);
        check_out(0, "exact46_1500");
        clear_q();

        // Split: 1600 -> 1500 + 100; 1501 -> 1500 + 1 padded
        e0 = err_cnt_a;
        exp_seg(0, 1500, 0);
        exp_seg(0, 100, 1500);
        exp_seg(0, 1500, 9);
        exp_seg(0, 1, 1509);
        send_pkt(0, 1600, 0, 1, 1);
        send_pkt(0, 1501, 9, 1, 1);
        check_out(0, "split");
        chk("split no err", err_cnt_a - e0, 0);
        chk("split no trunc", trunc_cnt_a, 0);
        clear_q();

        // Truncate: 1600 -> 1500, one trunc pulse, next packet unaffected
        exp_seg(1, 1500, 0);
        exp_seg(1, 20, 5);
        send_pkt(1, 1600, 0, 1, 1);
        send_pkt(1, 20, 5, 1, 1);
        check_out(1, "trunc");
        chk("trunc pulse count", trunc_cnt_b, 1);
        chk("trunc no err", err_cnt_b, 0);
        clear_q();

        // Backpressure: two 2000-beat bursts with downstream ready 1 in 3
        rdy_mode = 1;
        exp_seg(0, 1500, 7);
        exp_seg(0, 500, 1507);
        exp_seg(0, 1500, 3000);
        exp_seg(0, 500, 4500);
        send_pkt(0, 2000, 7, 1, 1);
        send_pkt(0, 2000, 3000, 1, 1);
        check_out(0, "backpressure");
        chk("backpressure din_rdy dropped", saw_full, 1);
        chk("backpressure hold stable", hold_viol, 0);
        rdy_mode = 0;
        clear_q();

        // Missing eop: second sop closes the first segment
        e0 = err_cnt_a;
        exp_seg(0, 20, 50);
        exp_seg(0, 10, 90);
        send_pkt(0, 20, 50, 1, 0);
        send_pkt(0, 10, 90, 1, 1);
        check_out(0, "missing eop");
        chk("missing eop err", err_cnt_a - e0, 1);
        clear_q();

        // Beat without sop outside a packet opens one
        e0 = err_cnt_a;
        exp_seg(0, 10, 120);
        send_pkt(0, 10, 120, 0, 1);
        check_out(0, "no sop");
        chk("no sop err", err_cnt_a - e0, 1);
        clear_q();

        // Reset mid-packet with a stalled output beat pending
        rdy_mode = 2;
        send_pkt(0, 30, 200, 1, 1);
        send_pkt(0, 5, 240, 1, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("pre-reset stalled vld", dvld_a, 1);
        chk("pre-reset stalled sop", dsop_a, 1);
        #2 rst = 1'b1;
        #1;
        chk("async reset dout_vld", dvld_a, 0);
        chk("async reset dout_sop", dsop_a, 0);
        chk("async reset dout_eop", deop_a, 0);
        chk("async reset dout", dout_a, 0);
        chk("async reset din_rdy", rdy_a, 1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        rdy_mode = 0;
        clear_q();
        repeat (2) @(posedge clk);
        #1;
        e0 = err_cnt_a;
        exp_seg(0, 12, 33);
        send_pkt(0, 12, 33, 1, 1);
        check_out(0, "post reset");
        chk("post reset no err", err_cnt_a - e0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pkt_len_norm.md
Name: pkt_len_norm

Overview:
- Parametrised packet length normaliser for the byte-stream path.
- Pads undersize packets to MIN_LEN with PAD_BYTE and bounds oversize packets at MAX_LEN. Oversize handling is selectable: split the excess into follow-on packets, or truncate and discard it.
- Store-and-forward: data FIFO plus length FIFO, with ready/valid backpressure on both sides.
- Sits between the ingress framer and the downstream MAC-side formatter.

Parameters:
- DATA_W, 8: data bus width; one beat = one byte-lane word.
- MIN_LEN, 46: minimum output packet length in beats. Must be ≥1.
- MAX_LEN, 1500: maximum output packet length in beats. Must be ≥ MIN_LEN.
- SPLIT_MODE, 1: oversize handling.
  - 1: split the excess into new packets.
  - 0: truncate to MAX_LEN and discard the rest.
- PAD_BYTE, 0: value driven on dout during pad beats, DATA_W wide.
- DFIFO_DEPTH, 2048: data FIFO depth in beats, power of 2, ≥ MAX_LEN.
- LFIFO_DEPTH, 16: length FIFO depth in entries, power of 2.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset. One clock; reset is asynchronous and active-high.
- din, in, DATA_W: input data.
- din_vld, in, 1: input beat valid.
- din_sop, in, 1: first beat of packet. Qualified by din_vld.
- din_eop, in, 1: last beat of packet. Qualified by din_vld.
- din_rdy, out, 1: input accept. A beat transfers when din_vld && din_rdy.
- dout, out, DATA_W: output data.
- dout_vld, out, 1: output beat valid.
- dout_sop, out, 1: first beat of output packet.
- dout_eop, out, 1: last beat of output packet.
- dout_rdy, in, 1: downstream accept.
- trunc_pulse, out, 1: one-cycle pulse when a packet is truncated (SPLIT_MODE=0).
- err_pulse, out, 1: one-cycle pulse on framing error.

Behaviour:
- Reset: all outputs 0 except din_rdy. Both FIFOs are emptied, all counters are 0, and the FSM is in IDLE. A reset mid-packet discards all buffered data; no partial packet is emitted after reset.
- din_rdy is registered and equals (data FIFO has ≥1 free slot) AND (length FIFO not full). While din_rdy=0, upstream holds its beat.
- Write side: seg_cnt, width clog2(MAX_LEN+1), counts accepted beats in the current segment.
- A segment closes on the first of:
  - an accepted din_eop;
  - seg_cnt reaching MAX_LEN (the MAX_LEN-th beat);
  - an accepted din_sop while a segment is open.
- On segment close:
  - The closing beat is stored with its seg_last bit = 1.
  - The segment length is pushed into the length FIFO in the same cycle.
  - seg_cnt returns to 0.
- Exactly MAX_LEN beats with eop on the last beat forms one segment; no empty segment is generated.
- Oversize with SPLIT_MODE=1: the next beat opens a new segment, which is emitted with dout_sop.
- Oversize with SPLIT_MODE=0: beats after the MAX_LEN-th are accepted with din_rdy kept high and discarded up to and including din_eop. trunc_pulse fires once per truncated packet, on the first discarded beat.
- Framing errors: err_pulse fires for one cycle on either of:
  - din_sop while a segment is open. The open segment closes as above; the sop beat starts a new segment.
  - A beat with no open segment and din_sop=0. That beat opens a segment as if sop were set.
- Read FSM states: IDLE, DATA, PAD.
  - IDLE: length FIFO non-empty → pop the entry into len_r, go to DATA.
  - DATA: present data FIFO head. The beat advances on dout_vld && dout_rdy. The first beat has dout_sop=1.
  - DATA, on the beat with seg_last: if len_r ≥ MIN_LEN, dout_eop=1 and go to IDLE. Otherwise go to PAD with pad_cnt = MIN_LEN − len_r.
  - PAD: dout=PAD_BYTE, dout_vld=1. pad_cnt decrements per accepted beat. The beat with pad_cnt==1 has dout_eop=1, then go to IDLE.
- MIN_LEN=1 disables padding.
- Output holding: dout, dout_vld, dout_sop and dout_eop stay stable while dout_vld && !dout_rdy.
- Output registers are arranged so consecutive packets stream back-to-back: IDLE is transited in one cycle, with at most one bubble beat between packets.
- Latency: the first output beat is valid no later than 3 cycles after its length entry is pushed.
- Because the length is pushed only after the segment's last beat is written, DATA never underflows the data FIFO.
- Simultaneous push and pop on either FIFO in the same cycle is legal. FIFO occupancy is unchanged in that case.

Test Plan:
- 10-beat packet, MIN_LEN=46 → 46 output beats: dout_sop on beat 1, beats 11–46 = PAD_BYTE, dout_eop on beat 46 only.
- Packets of 46 and 1500 beats → output identical to input; no pad beats; one sop and one eop each.
- 1600-beat packet, SPLIT_MODE=1 → 1500-beat packet, then 100-beat packet padded to 100 (no pad). 1501-beat packet → 1500-beat packet + 1 data beat + 45 pad beats.
- 1600-beat packet, SPLIT_MODE=0 → single 1500-beat packet; trunc_pulse high for 1 cycle; next packet unaffected.
- dout_rdy toggled with a 1-in-3 duty plus a 2000-beat input burst → din_rdy deasserts when the FIFO is full; no beat lost or duplicated; output held stable while stalled.
- Missing eop (two sops 20 beats apart) → err_pulse=1, first segment emitted as 20 data + 26 pad beats. Then assert rst mid-packet → all outputs 0 within the same cycle; first post-reset packet correct.
